// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle main controller and the MIPS datapath.
// The master side (controller) samples IR fields and the ALU flag and drives
// every datapath enable and select.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       PCWr;
    logic [1:0] NPCSel;
    logic       IRWr;
    logic       RegWr;
    logic [1:0] RegDst;
    logic [1:0] MemToReg;
    logic       ALUSrc;
    logic [1:0] ExtOp;
    logic [1:0] ALUOp;
    logic       MemWr;
    logic       done;
    logic [2:0] state;

    modport master (
        input  op, funct, zero,
        output PCWr, NPCSel, IRWr, RegWr, RegDst, MemToReg,
               ALUSrc, ExtOp, ALUOp, MemWr, done, state
    );

    modport slave (
        output op, funct, zero,
        input  PCWr, NPCSel, IRWr, RegWr, RegDst, MemToReg,
               ALUSrc, ExtOp, ALUOp, MemWr, done, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the PCOCD MIPS core.
// Walks each instruction through FETCH/DECODE/EXE/MEM/WB and updates the PC
// exactly once, in the retiring cycle, so branch/jump targets are always
// computed from the executing instruction's PC.
// Optional build macro MC_ILLEGAL_TRAP_EN: unknown instructions enter a
// sticky TRAP state; otherwise they retire as a nop from DECODE.
module mc_ctrl #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic         clk,
    input  logic         reset,
    mc_ctrl_if.master    bus
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_WAIT);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_REG  = 2'b01;
    localparam logic [1:0] NPC_J    = 2'b10;
    localparam logic [1:0] NPC_BEQ  = 2'b11;

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_RA   = 2'b10;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_PC4   = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic is_rtype, is_addu, is_subu, is_jr, is_j, is_jal;
    logic is_beq, is_ori, is_lui, is_lw, is_sw, is_legal;

    logic       pc_wr, ir_wr, reg_wr, mem_wr, alu_src;
    logic [1:0] npc_sel, reg_dst, mem_to_reg, ext_op, alu_op;

    // Instruction decode from the latched IR fields.
    always_comb begin
        is_rtype = (bus.op == OP_RTYPE);
        is_addu  = is_rtype && (bus.funct == FN_ADDU);
        is_subu  = is_rtype && (bus.funct == FN_SUBU);
        is_jr    = is_rtype && (bus.funct == FN_JR);
        is_j     = (bus.op == OP_J);
        is_jal   = (bus.op == OP_JAL);
        is_beq   = (bus.op == OP_BEQ);
        is_ori   = (bus.op == OP_ORI);
        is_lui   = (bus.op == OP_LUI);
        is_lw    = (bus.op == OP_LW);
        is_sw    = (bus.op == OP_SW);
        is_legal = is_addu | is_subu | is_jr | is_j | is_jal | is_beq |
                   is_ori | is_lui | is_lw | is_sw;
    end

    // State and MEM stall counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_wr      = 1'b0;
        npc_sel    = NPC_PC4;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = WB_ALU;
        alu_src    = 1'b0;
        ext_op     = EXT_ZERO;
        alu_op     = ALU_ADD;
        mem_wr     = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_wr   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_j) begin
                    pc_wr   = 1'b1;
                    npc_sel = NPC_J;
                    state_d = S_FETCH;
                end else if (is_jr) begin
                    pc_wr   = 1'b1;
                    npc_sel = NPC_REG;
                    state_d = S_FETCH;
                end else if (is_jal) begin
                    state_d = S_WB;
                end else if (is_legal) begin
                    state_d = S_EXE;
                end else begin
`ifdef MC_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    pc_wr   = 1'b1;
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXE: begin
                if (is_addu || is_subu) begin
                    alu_op  = is_subu ? ALU_SUB : ALU_ADD;
                    state_d = S_WB;
                end else if (is_ori) begin
                    alu_src = 1'b1;
                    ext_op  = EXT_ZERO;
                    alu_op  = ALU_OR;
                    state_d = S_WB;
                end else if (is_lui) begin
                    alu_src = 1'b1;
                    ext_op  = EXT_LUI;
                    alu_op  = ALU_ADD;
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    alu_src = 1'b1;
                    ext_op  = EXT_SIGN;
                    alu_op  = ALU_ADD;
                    cnt_d   = '0;
                    state_d = S_MEM;
                end else if (is_beq) begin
                    alu_op  = ALU_SUB;
                    pc_wr   = 1'b1;
                    npc_sel = bus.zero ? NPC_BEQ : NPC_PC4;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (cnt_q == MEM_LAST) begin
                    cnt_d = '0;
                    if (is_sw) begin
                        mem_wr  = 1'b1;
                        pc_wr   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                reg_wr  = 1'b1;
                pc_wr   = 1'b1;
                state_d = S_FETCH;
                if (is_jal) begin
                    reg_dst    = DST_RA;
                    mem_to_reg = WB_PC4;
                    npc_sel    = NPC_J;
                end else if (is_lw) begin
                    mem_to_reg = WB_MEM;
                end else if (is_rtype) begin
                    reg_dst    = DST_RD;
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Enables are forced low while reset is held so an aborted instruction writes nothing.
    assign bus.PCWr     = pc_wr  & ~reset;
    assign bus.done     = pc_wr  & ~reset;
    assign bus.IRWr     = ir_wr  & ~reset;
    assign bus.RegWr    = reg_wr & ~reset;
    assign bus.MemWr    = mem_wr & ~reset;
    assign bus.NPCSel   = npc_sel;
    assign bus.RegDst   = reg_dst;
    assign bus.MemToReg = mem_to_reg;
    assign bus.ALUSrc   = alu_src;
    assign bus.ExtOp    = ext_op;
    assign bus.ALUOp    = alu_op;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: a cycle-by-cycle expected trace is built per instruction
// from the controller's instruction-level behaviour and compared every cycle.
module tb_mc_ctrl;

    localparam int unsigned MEM_WAIT = 2;

    logic clk = 1'b0;
    logic reset;

    mc_ctrl_if bus();

    mc_ctrl #(.MEM_WAIT(MEM_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       pcwr;
        logic [1:0] npc;
        logic       irwr;
        logic       regwr;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic       asrc;
        logic [1:0] ext;
        logic [1:0] aop;
        logic       memwr;
        logic       done;
    } obs_t;

    typedef enum {K_ADDU, K_SUBU, K_JR, K_J, K_JAL, K_BEQ, K_ORI, K_LUI,
                  K_LW, K_SW, K_BAD} kind_t;

    int   total = 0;
    int   bad   = 0;
    obs_t expq[$];

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                if (fn == 6'h21) return K_ADDU;
                if (fn == 6'h23) return K_SUBU;
                if (fn == 6'h08) return K_JR;
                return K_BAD;
            end
            6'h02: return K_J;
            6'h03: return K_JAL;
            6'h04: return K_BEQ;
            6'h0d: return K_ORI;
            6'h0f: return K_LUI;
            6'h23: return K_LW;
            6'h2b: return K_SW;
            default: return K_BAD;
        endcase
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.st    = bus.state;
        o.pcwr  = bus.PCWr;
        o.npc   = bus.NPCSel;
        o.irwr  = bus.IRWr;
        o.regwr = bus.RegWr;
        o.rdst  = bus.RegDst;
        o.m2r   = bus.MemToReg;
        o.asrc  = bus.ALUSrc;
        o.ext   = bus.ExtOp;
        o.aop   = bus.ALUOp;
        o.memwr = bus.MemWr;
        o.done  = bus.done;
        return o;
    endfunction

    // Expected per-cycle trace of one instruction, starting in FETCH.
    task automatic build(input kind_t k, input logic z);
        obs_t r;
        expq.delete();
        r = '0; r.st = 3'd0; r.irwr = 1'b1;
        expq.push_back(r);
        r = '0; r.st = 3'd1;
        if (k == K_J || k == K_JR || k == K_BAD) begin
            r.pcwr = 1'b1; r.done = 1'b1;
            r.npc  = (k == K_J) ? 2'b10 : (k == K_JR) ? 2'b01 : 2'b00;
            expq.push_back(r);
            return;
        end
        expq.push_back(r);
        if (k != K_JAL) begin
            r = '0; r.st = 3'd2;
            case (k)
                K_SUBU: r.aop = 2'b01;
                K_ORI:  begin r.asrc = 1'b1; r.ext = 2'b00; r.aop = 2'b10; end
                K_LUI:  begin r.asrc = 1'b1; r.ext = 2'b10; r.aop = 2'b00; end
                K_LW, K_SW: begin r.asrc = 1'b1; r.ext = 2'b01; end
                K_BEQ:  begin
                    r.aop = 2'b01; r.pcwr = 1'b1; r.done = 1'b1;
                    r.npc = z ? 2'b11 : 2'b00;
                end
                default: r.aop = 2'b00;
            endcase
            expq.push_back(r);
            if (k == K_BEQ) return;
            if (k == K_LW || k == K_SW) begin
                for (int i = 0; i < int'(MEM_WAIT); i++) begin
                    r = '0; r.st = 3'd3;
                    expq.push_back(r);
                end
                r = '0; r.st = 3'd3;
                if (k == K_SW) begin
                    r.memwr = 1'b1; r.pcwr = 1'b1; r.done = 1'b1;
                    expq.push_back(r);
                    return;
                end
                expq.push_back(r);
            end
        end
        r = '0; r.st = 3'd4; r.regwr = 1'b1; r.pcwr = 1'b1; r.done = 1'b1;
        case (k)
            K_JAL:          begin r.rdst = 2'b10; r.m2r = 2'b10; r.npc = 2'b10; end
            K_LW:           r.m2r = 2'b01;
            K_ADDU, K_SUBU: r.rdst = 2'b01;
            default:        r.rdst = 2'b00;
        endcase
        expq.push_back(r);
    endtask

    // Called at a falling edge with the controller in FETCH; returns likewise.
    task automatic run_instr(input string name, input logic [5:0] op,
                             input logic [5:0] fn, input logic z);
        obs_t o;
        build(classify(op, fn), z);
        bus.op = op; bus.funct = fn; bus.zero = z;
        for (int i = 0; i < expq.size(); i++) begin
            #1;
            o = observe();
            total++;
            if (o !== expq[i]) begin
                bad++;
                $display("FAIL %s cyc%0d got=%h want=%h", name, i, 19'(o), 19'(expq[i]));
            end
            @(negedge clk);
        end
    endtask

    task automatic check_now(input string name, input obs_t want);
        obs_t o;
        o = observe();
        total++;
        if (o !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, 19'(o), 19'(want));
        end
    endtask

    task automatic test_reset();
        obs_t w;
        reset = 1'b1;
        bus.op = 6'h00; bus.funct = 6'h21; bus.zero = 1'b0;
        @(negedge clk);
        #1;
        w = '0;
        check_now("reset_hold", w);
        @(negedge clk);
        reset = 1'b0;
        #1;
        w = '0; w.irwr = 1'b1;
        check_now("reset_release", w);
    endtask

    task automatic test_reset_mid();
        obs_t w;
        bus.op = 6'h00; bus.funct = 6'h21; bus.zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        w = '0; w.st = 3'd2;
        check_now("mid_exe", w);
        reset = 1'b1;
        #1;
        w = '0;
        check_now("mid_reset_async", w);
        @(negedge clk);
        #1;
        check_now("mid_reset_held", w);
        reset = 1'b0;
        #1;
        w = '0; w.irwr = 1'b1;
        check_now("mid_reset_fetch", w);
        run_instr("after_mid_reset", 6'h00, 6'h21, 1'b0);
    endtask

    task automatic test_alu();
        run_instr("addu", 6'h00, 6'h21, 1'b0);
        run_instr("subu", 6'h00, 6'h23, 1'b1);
        run_instr("ori",  6'h0d, 6'h15, 1'b0);
        run_instr("lui",  6'h0f, 6'h00, 1'b0);
    endtask

    task automatic test_mem();
        run_instr("lw", 6'h23, 6'h00, 1'b0);
        run_instr("sw", 6'h2b, 6'h3f, 1'b1);
    endtask

    task automatic test_branch();
        run_instr("beq_taken",  6'h04, 6'h00, 1'b1);
        run_instr("beq_not",    6'h04, 6'h00, 1'b0);
        run_instr("j",          6'h02, 6'h11, 1'b0);
        run_instr("jr",         6'h00, 6'h08, 1'b0);
        run_instr("jal",        6'h03, 6'h00, 1'b1);
    endtask

    task automatic test_illegal();
`ifdef MC_ILLEGAL_TRAP_EN
        obs_t w;
        bus.op = 6'h3f; bus.funct = 6'h00; bus.zero = 1'b0;
        #1;
        w = '0; w.irwr = 1'b1;
        check_now("trap_fetch", w);
        @(negedge clk);
        #1;
        w = '0; w.st = 3'd1;
        check_now("trap_decode", w);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            w = '0; w.st = 3'd7;
            check_now("trap_hold", w);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_instr("after_trap", 6'h0d, 6'h00, 1'b0);
`else
        run_instr("bad_op",    6'h3f, 6'h00, 1'b0);
        run_instr("bad_funct", 6'h00, 6'h3f, 1'b1);
`endif
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [11];
        logic [5:0] fns [3];
        logic [5:0] op, fn;
        ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h3f, 6'h11};
        fns = '{6'h21, 6'h23, 6'h08};
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 4) == 0) fn = 6'($urandom);
            else                           fn = fns[$urandom_range(0, 2)];
`ifdef MC_ILLEGAL_TRAP_EN
            if (classify(op, fn) == K_BAD) begin
                op = 6'h00; fn = 6'h21;
            end
`endif
            run_instr("random", op, fn, 1'($urandom));
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.op = '0; bus.funct = '0; bus.zero = 1'b0;
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_reset_mid();
        test_illegal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
